tlc_monitor: RTL and testbench

TLC_MONITOR -- requirements
Module: tlc_monitor

---
 rtl/tlc_pkg.sv | 102 ++++++++++
 rtl/sat_cnt8.sv | 27 ++
 rtl/tlc_monitor.sv | 114 +++++++++++
 tb/tb_tlc_monitor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light controller monitor:
// phase/state codes, error codes, lamp bit positions and decode helpers.
package tlc_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned LAMP_W  = 3;

  // Lamp bit positions within a {R,Y,G} triple
  localparam int unsigned LAMP_R = 2;
  localparam int unsigned LAMP_Y = 1;
  localparam int unsigned LAMP_G = 0;

  localparam logic [LAMP_W-1:0] LAMP_RED = LAMP_W'(1 << LAMP_R);
  localparam logic [LAMP_W-1:0] LAMP_YEL = LAMP_W'(1 << LAMP_Y);
  localparam logic [LAMP_W-1:0] LAMP_GRN = LAMP_W'(1 << LAMP_G);

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE   = 3'd0,
    PH_A_GO   = 3'd1,
    PH_A_WARN = 3'd2,
    PH_RED_AB = 3'd3,
    PH_B_GO   = 3'd4,
    PH_B_WARN = 3'd5,
    PH_RED_BA = 3'd6,
    PH_FAULT  = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    PAT_ILLEGAL = 3'd0,
    PAT_A_GO    = 3'd1,
    PAT_A_WARN  = 3'd2,
    PAT_ALL_RED = 3'd3,
    PAT_B_GO    = 3'd4,
    PAT_B_WARN  = 3'd5
  } pat_e;

  localparam logic [CODE_W-1:0] ERR_NONE        = 3'd0;
  localparam logic [CODE_W-1:0] ERR_ILLEGAL     = 3'd1;
  localparam logic [CODE_W-1:0] ERR_BAD_SEQ     = 3'd2;
  localparam logic [CODE_W-1:0] ERR_SHORT_GREEN = 3'd3;
  localparam logic [CODE_W-1:0] ERR_LONG_YELLOW = 3'd4;

  // Classify a lamp pair into one of the five legal patterns or ILLEGAL
  function automatic pat_e decode_pat(input logic [LAMP_W-1:0] a,
                                      input logic [LAMP_W-1:0] b);
    pat_e p;
    p = PAT_ILLEGAL;
    if      (a == LAMP_GRN && b == LAMP_RED) p = PAT_A_GO;
    else if (a == LAMP_YEL && b == LAMP_RED) p = PAT_A_WARN;
    else if (a == LAMP_RED && b == LAMP_RED) p = PAT_ALL_RED;
    else if (a == LAMP_RED && b == LAMP_GRN) p = PAT_B_GO;
    else if (a == LAMP_RED && b == LAMP_YEL) p = PAT_B_WARN;
    return p;
  endfunction

  // Lamp pattern expected while sitting in a phase
  function automatic pat_e phase_pat(input phase_e s);
    pat_e p;
    case (s)
      PH_A_GO:   p = PAT_A_GO;
      PH_A_WARN: p = PAT_A_WARN;
      PH_RED_AB: p = PAT_ALL_RED;
      PH_B_GO:   p = PAT_B_GO;
      PH_B_WARN: p = PAT_B_WARN;
      PH_RED_BA: p = PAT_ALL_RED;
      default:   p = PAT_ILLEGAL;
    endcase
    return p;
  endfunction

  // Successor in the legal ring; IDLE/FAULT map to themselves
  function automatic phase_e next_phase(input phase_e s);
    phase_e n;
    case (s)
      PH_A_GO:   n = PH_A_WARN;
      PH_A_WARN: n = PH_RED_AB;
      PH_RED_AB: n = PH_B_GO;
      PH_B_GO:   n = PH_B_WARN;
      PH_B_WARN: n = PH_RED_BA;
      PH_RED_BA: n = PH_A_GO;
      default:   n = s;
    endcase
    return n;
  endfunction

  // Phase adopted from IDLE; all-red is taken as the B-to-A red so A goes next
  function automatic phase_e adopt_phase(input pat_e p);
    phase_e n;
    case (p)
      PAT_A_GO:    n = PH_A_GO;
      PAT_A_WARN:  n = PH_A_WARN;
      PAT_ALL_RED: n = PH_RED_BA;
      PAT_B_GO:    n = PH_B_GO;
      PAT_B_WARN:  n = PH_B_WARN;
      default:     n = PH_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit saturating counter with clear / load-to-one / increment.
// Ports: clk, rst_n (async active-low), clr, load1, inc -> cnt.
// Priority: clr over load1 over inc; holds at all-ones.
module sat_cnt8
  import tlc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load1,
  input  logic               inc,
  output logic [DWELL_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= DWELL_W'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/tlc_monitor.sv
// Passive monitor of a two-direction traffic-light controller.
// Tracks the lamp phase sequence, times green/yellow dwell in valid samples,
// and latches the first protocol violation until cleared.
// Ports: ck, rn (async active-low), valid, lamp_a/lamp_b {R,Y,G}, clr ->
//        phase, phase_chg, dwell, err, err_code (all registered).
module tlc_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MAX_YELLOW = 4
) (
  input  logic               ck,
  input  logic               rn,
  input  logic               valid,
  input  logic [LAMP_W-1:0]  lamp_a,
  input  logic [LAMP_W-1:0]  lamp_b,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_chg,
  output logic [DWELL_W-1:0] dwell,
  output logic               err,
  output logic [CODE_W-1:0]  err_code
);

  phase_e              state_q, state_d;
  pat_e                pat;
  logic [CODE_W-1:0]   fault_code;
  logic                accept, stay;
  logic                is_green, is_warn;
  logic                phase_chg_d, err_d;
  logic [CODE_W-1:0]   err_code_d;
  logic                cnt_clr, cnt_load, cnt_inc;

  assign pat      = decode_pat(lamp_a, lamp_b);
  assign is_green = (state_q == PH_A_GO)   || (state_q == PH_B_GO);
  assign is_warn  = (state_q == PH_A_WARN) || (state_q == PH_B_WARN);

  // State register
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) state_q <= PH_IDLE;
    else     state_q <= state_d;
  end

  // Next state and violation detection; checks ordered so the lowest code wins
  always_comb begin
    state_d    = state_q;
    fault_code = ERR_NONE;
    accept     = 1'b0;
    stay       = 1'b0;
    if (state_q == PH_FAULT) begin
      if (clr) state_d = PH_IDLE;
    end else if (valid) begin
      if (pat == PAT_ILLEGAL) begin
        fault_code = ERR_ILLEGAL;
      end else if (state_q == PH_IDLE) begin
        accept  = 1'b1;
        state_d = adopt_phase(pat);
      end else if (pat == phase_pat(state_q)) begin
        // dwell is pre-increment, so dwell >= MAX means the stay would exceed it
        if (is_warn && (32'(dwell) >= MAX_YELLOW)) fault_code = ERR_LONG_YELLOW;
        else                                       stay       = 1'b1;
      end else if (pat == phase_pat(next_phase(state_q))) begin
        if (is_green && (32'(dwell) < MIN_GREEN)) begin
          fault_code = ERR_SHORT_GREEN;
        end else begin
          accept  = 1'b1;
          state_d = next_phase(state_q);
        end
      end else begin
        fault_code = ERR_BAD_SEQ;
      end
      if (fault_code != ERR_NONE) state_d = PH_FAULT;
    end
  end

  // Output/next-register values; a new error overrides a same-cycle clear
  always_comb begin
    phase_chg_d = accept;
    cnt_clr     = (fault_code != ERR_NONE) || (state_q == PH_FAULT);
    cnt_load    = accept;
    cnt_inc     = stay;
    err_d       = clr ? 1'b0 : err;
    err_code_d  = clr ? ERR_NONE : err_code;
    if (fault_code != ERR_NONE) begin
      if (!err_d) err_code_d = fault_code;
      err_d = 1'b1;
    end
  end

  // Registered flags
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      phase_chg <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      phase_chg <= phase_chg_d;
      err       <= err_d;
      err_code  <= err_code_d;
    end
  end

  assign phase = state_q;

  sat_cnt8 u_dwell (
    .clk   (ck),
    .rst_n (rn),
    .clr   (cnt_clr),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .cnt   (dwell)
  );

endmodule

// File: tb/tb_tlc_monitor.sv
// Scoreboard bench for tlc_monitor: a behavioural model pushes the expected
// outputs for every driven sample; they are popped and compared one cycle later.
module tb_tlc_monitor;

  localparam int MIN_GREEN  = 8;
  localparam int MAX_YELLOW = 4;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic       ck;
  logic       rn;
  logic       valid;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       clr;
  logic [2:0] phase;
  logic       phase_chg;
  logic [7:0] dwell;
  logic       err;
  logic [2:0] err_code;

  tlc_monitor #(.MIN_GREEN(MIN_GREEN), .MAX_YELLOW(MAX_YELLOW)) dut (
    .ck        (ck),
    .rn        (rn),
    .valid     (valid),
    .lamp_a    (lamp_a),
    .lamp_b    (lamp_b),
    .clr       (clr),
    .phase     (phase),
    .phase_chg (phase_chg),
    .dwell     (dwell),
    .err       (err),
    .err_code  (err_code)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    int phase;
    int chg;
    int dwell;
    int err;
    int code;
  } exp_t;

  exp_t sb[$];
  int   seq[$];
  bit   rec_on;
  int   n_checks;
  int   n_fail;

  // model state
  int m_phase, m_dwell, m_err, m_code;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // 1..5 legal patterns numbered like their phases, 9 = all red, 0 = illegal
  function automatic int pat_of(input logic [2:0] a, input logic [2:0] b);
    if (a == LG && b == LR) return 1;
    if (a == LY && b == LR) return 2;
    if (a == LR && b == LR) return 9;
    if (a == LR && b == LG) return 4;
    if (a == LR && b == LY) return 5;
    return 0;
  endfunction

  function automatic int ph_pat(input int ph);
    return (ph == 3 || ph == 6) ? 9 : ph;
  endfunction

  task automatic model_step(input logic v, input logic [2:0] a, input logic [2:0] b,
                            input logic c);
    int   p, nxt, code, chg;
    exp_t e;
    code = 0;
    chg  = 0;
    if (m_phase == 7) begin
      if (c) begin
        m_phase = 0; m_err = 0; m_code = 0;
      end
    end else begin
      if (c) begin
        m_err = 0; m_code = 0;
      end
      if (v) begin
        p = pat_of(a, b);
        if (p == 0) begin
          code = 1;
        end else if (m_phase == 0) begin
          m_phase = (p == 9) ? 6 : p;
          m_dwell = 1;
          chg     = 1;
        end else begin
          nxt = (m_phase == 6) ? 1 : m_phase + 1;
          if (p == ph_pat(m_phase)) begin
            if ((m_phase == 2 || m_phase == 5) && (m_dwell + 1 > MAX_YELLOW)) code = 4;
            else if (m_dwell < 255) m_dwell++;
          end else if (p == ph_pat(nxt)) begin
            if ((m_phase == 1 || m_phase == 4) && (m_dwell < MIN_GREEN)) code = 3;
            else begin
              m_phase = nxt; m_dwell = 1; chg = 1;
            end
          end else begin
            code = 2;
          end
        end
        if (code != 0) begin
          if (m_err == 0) m_code = code;
          m_err = 1; m_phase = 7; m_dwell = 0;
        end
      end
    end
    e.phase = m_phase; e.chg = chg; e.dwell = m_dwell; e.err = m_err; e.code = m_code;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("phase", int'(phase), e.phase);
    chk("phase_chg", int'(phase_chg), e.chg);
    chk("dwell", int'(dwell), e.dwell);
    chk("err", int'(err), e.err);
    chk("err_code", int'(err_code), e.code);
    if (rec_on && phase_chg) seq.push_back(int'(phase));
  endtask

  task automatic step(input logic v, input logic [2:0] a, input logic [2:0] b,
                      input logic c);
    @(negedge ck);
    valid = v; lamp_a = a; lamp_b = b; clr = c;
    model_step(v, a, b, c);
    @(posedge ck);
    #1;
    compare();
  endtask

  task automatic hold(input int n, input logic [2:0] a, input logic [2:0] b);
    for (int i = 0; i < n; i++) step(1'b1, a, b, 1'b0);
  endtask

  // From any state: force FAULT with an illegal pair, then clear to IDLE
  task automatic go_idle();
    step(1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b0, 3'b000, 3'b000, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_chg"}, int'(phase_chg), 0);
    chk({tag, "_dwell"}, int'(dwell), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_code"}, int'(err_code), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq[7];
    logic [2:0] ra, rb, la, lb;
    exp_seq = '{1, 2, 3, 4, 5, 6, 1};
    n_checks = 0; n_fail = 0; rec_on = 1'b0;
    m_phase = 0; m_dwell = 0; m_err = 0; m_code = 0;
    rn = 1'b0; valid = 1'b0; lamp_a = '0; lamp_b = '0; clr = 1'b0;

    #12;
    chk_zero("reset");
    @(negedge ck);
    rn = 1'b1;

    // Full legal cycle with a VALID gap in the first green
    rec_on = 1'b1;
    hold(4, LG, LR); step(1'b0, LY, LR, 1'b0); hold(4, LG, LR);
    hold(3, LY, LR); hold(2, LR, LR);
    hold(8, LR, LG); hold(3, LR, LY); hold(2, LR, LR);
    hold(1, LG, LR);
    rec_on = 1'b0;
    chk("cycle_pulses", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++) chk("cycle_seq", seq[i], exp_seq[i]);
    chk("cycle_err", int'(err), 0);

    // Short green: A_GO for 5 samples then yellow
    hold(4, LG, LR);
    hold(1, LY, LR);
    chk("short_green_code", int'(err_code), 3);
    chk("short_green_phase", int'(phase), 7);
    step(1'b1, LG, LR, 1'b1);

    // Long yellow, lamps ignored in FAULT, then clear
    hold(5, LY, LR);
    chk("long_yellow_code", int'(err_code), 4);
    hold(2, 3'b111, 3'b111);
    chk("fault_sticky_code", int'(err_code), 4);
    step(1'b0, 3'b000, 3'b000, 1'b1);
    chk("clr_err", int'(err), 0);
    chk("clr_phase", int'(phase), 0);

    // Illegal pair in B_GO, then bad sequence A_GO -> B_GO
    hold(3, LR, LG);
    step(1'b1, 3'b011, LR, 1'b0);
    chk("illegal_code", int'(err_code), 1);
    step(1'b0, 3'b000, 3'b000, 1'b1);
    hold(9, LG, LR);
    step(1'b1, LR, LG, 1'b0);
    chk("bad_seq_code", int'(err_code), 2);
    step(1'b0, 3'b000, 3'b000, 1'b1);

    // Clear outside FAULT is harmless; clear with new error -> error wins
    hold(2, LG, LR);
    step(1'b1, LG, LR, 1'b1);
    chk("clr_run_phase", int'(phase), 1);
    step(1'b1, 3'b000, 3'b000, 1'b1);
    chk("clr_vs_err", int'(err), 1);
    step(1'b0, 3'b000, 3'b000, 1'b1);

    // Dwell saturation with VALID gaps
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 25) step(1'b0, LG, LR, 1'b0);
      step(1'b1, LG, LR, 1'b0);
    end
    chk("dwell_sat", int'(dwell), 255);
    go_idle();

    // Random traffic, biased toward held or legal pairs
    la = LG; lb = LR;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: begin la = LG; lb = LR; end
        1: begin la = LY; lb = LR; end
        2: begin la = LR; lb = LR; end
        3: begin la = LR; lb = LG; end
        4: begin la = LR; lb = LY; end
        5: begin ra = 3'($urandom); rb = 3'($urandom); la = ra; lb = rb; end
        default: ;
      endcase
      step(($urandom_range(0, 7) != 0), la, lb, ($urandom_range(0, 15) == 0));
    end
    go_idle();

    // Async reset mid B_WARN, then restart from all-red
    hold(8, LG, LR); hold(1, LY, LR); hold(1, LR, LR);
    hold(8, LR, LG); hold(2, LR, LY);
    chk("pre_reset_phase", int'(phase), 5);
    #2;
    rn = 1'b0;
    #1;
    chk_zero("async_rst");
    m_phase = 0; m_dwell = 0; m_err = 0; m_code = 0;
    @(negedge ck);
    rn = 1'b1;
    step(1'b1, LR, LR, 1'b0);
    chk("restart_phase", int'(phase), 6);
    chk("restart_err", int'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
